// File: rtl/cbs_window_gen.sv
// cbs_window_gen: 3x3 zero-padded window generator with two line buffers,
// stride 1/2 selection per frame and valid/ready on both sides.
module cbs_window_gen #(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 640
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stride2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH*DATA_W-1:0]     in_pixel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [9*CH*DATA_W-1:0]   out_window,
  output logic [14:0]              out_row,
  output logic [14:0]              out_col,
  output logic                     frame_done,
  output logic                     busy
);
  localparam int PW = CH * DATA_W;
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0] W_L   = 16'(IMG_W);
  localparam logic [15:0] WM1_L = 16'(IMG_W - 1);
  localparam logic [15:0] H_L   = 16'(IMG_H);
  localparam logic [15:0] HM1_L = 16'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EDGE, S_FLUSH} state_t;

  state_t           state_q, state_d;
  // (srow, scol) is the position of the next column shift: bottom-tap row
  // and column. scol == IMG_W is the trailing zero column of a row.
  logic [15:0]      srow_q, srow_d, scol_q, scol_d;
  logic             s2_q, s2_d, busy_q, busy_d, fdone_q, fdone_d, rdy_en_q;
  logic             out_valid_q, out_valid_d;
  logic [9*PW-1:0]  out_window_q, out_window_d, win_flat;
  logic [14:0]      out_row_q, out_row_d, out_col_q, out_col_d;

  logic [PW-1:0]    lb0_q [IMG_W];
  logic [PW-1:0]    lb1_q [IMG_W];
  logic [PW-1:0]    win_q [3][3];
  logic [PW-1:0]    win_d [3][3];
  logic [PW-1:0]    col_top, col_mid, col_bot;
  logic [AW-1:0]    addr;
  logic             in_col, emit, stall, accept, shift;

  // Decide whether a shift happens this cycle and whether it yields a window
  always_comb begin
    in_col   = (scol_q < W_L);
    addr     = in_col ? scol_q[AW-1:0] : '0;
    emit     = (srow_q != 16'd0) && (scol_q != 16'd0) && (scol_q <= W_L) &&
               (!s2_q || (srow_q[0] && scol_q[0]));
    stall    = emit && out_valid_q && !out_ready;
    in_ready = 1'b0;
    shift    = 1'b0;
    if ((state_q == S_IDLE) || (state_q == S_RUN))
      in_ready = rdy_en_q && !stall;
    accept = in_valid && in_ready;
    case (state_q)
      S_EDGE:  shift = !stall;
      S_FLUSH: shift = (scol_q <= W_L) && !stall;
      default: shift = accept;
    endcase
  end

  // Fetch the incoming column, shift the 3x3 array and mask off-image taps
  always_comb begin
    col_top = in_col ? lb0_q[addr] : '0;
    col_mid = in_col ? lb1_q[addr] : '0;
    col_bot = ((state_q == S_IDLE) || (state_q == S_RUN)) ? in_pixel : '0;
    for (int i = 0; i < 3; i++) begin
      win_d[0][i] = win_q[1][i];
      win_d[1][i] = win_q[2][i];
    end
    win_d[2][0] = col_top;
    win_d[2][1] = col_mid;
    win_d[2][2] = col_bot;
    win_flat = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if ((int'(srow_q) + i >= 2) && (int'(srow_q) + i < IMG_H + 2) &&
            (int'(scol_q) + j >= 2) && (int'(scol_q) + j < IMG_W + 2))
          win_flat[(i*3+j)*PW +: PW] = win_d[j][i];
      end
    end
  end

  // FSM next state, position counters and output register loading
  always_comb begin
    state_d      = state_q;
    srow_d       = srow_q;
    scol_d       = scol_q;
    s2_d         = s2_q;
    busy_d       = busy_q;
    fdone_d      = 1'b0;
    out_valid_d  = out_valid_q;
    out_window_d = out_window_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    if (shift && emit) begin
      out_valid_d  = 1'b1;
      out_window_d = win_flat;
      out_row_d    = 15'(srow_q - 16'd1);
      out_col_d    = 15'(scol_q - 16'd1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_RUN;
        s2_d    = stride2;
        busy_d  = 1'b1;
        srow_d  = 16'd0;
        scol_d  = 16'd1;
      end
      S_RUN: if (accept) begin
        if (scol_q == WM1_L) begin
          if (srow_q == 16'd0) begin
            srow_d = 16'd1;
            scol_d = 16'd0;
          end else begin
            scol_d  = W_L;
            state_d = S_EDGE;
          end
        end else begin
          scol_d = scol_q + 16'd1;
        end
      end
      S_EDGE: if (shift) begin
        scol_d = 16'd0;
        if (srow_q == HM1_L) begin
          state_d = S_FLUSH;
          srow_d  = H_L;
        end else begin
          state_d = S_RUN;
          srow_d  = srow_q + 16'd1;
        end
      end
      S_FLUSH: begin
        if (shift) begin
          scol_d = scol_q + 16'd1;
        end else if ((scol_q > W_L) && (!out_valid_q || out_ready)) begin
          fdone_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
          srow_d  = 16'd0;
          scol_d  = 16'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      srow_q       <= 16'd0;
      scol_q       <= 16'd0;
      s2_q         <= 1'b0;
      busy_q       <= 1'b0;
      fdone_q      <= 1'b0;
      rdy_en_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      out_row_q    <= 15'd0;
      out_col_q    <= 15'd0;
    end else begin
      state_q      <= state_d;
      srow_q       <= srow_d;
      scol_q       <= scol_d;
      s2_q         <= s2_d;
      busy_q       <= busy_d;
      fdone_q      <= fdone_d;
      rdy_en_q     <= 1'b1;
      out_valid_q  <= out_valid_d;
      out_window_q <= out_window_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
    end
  end

  // Line buffers and shift array; stale contents are masked by position
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[addr] <= col_mid;
      lb1_q[addr] <= in_pixel;
    end
    if (shift) begin
      for (int j = 0; j < 3; j++)
        for (int i = 0; i < 3; i++)
          win_q[j][i] <= win_d[j][i];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = fdone_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_cbs_window_gen.sv
// Testbench for cbs_window_gen: 4x3 image, 2 channels of 8 bits.
module tb_cbs_window_gen;
  localparam int DW = 8;
  localparam int CH = 2;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = CH * DW;

  logic              clk = 1'b0;
  logic              reset, stride2, in_valid, in_ready, out_valid, out_ready;
  logic              frame_done, busy;
  logic [PW-1:0]     in_pixel;
  logic [9*PW-1:0]   out_window;
  logic [14:0]       out_row, out_col;

  always #5 clk = ~clk;

  cbs_window_gen #(.DATA_W(DW), .CH(CH), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .stride2(stride2),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done), .busy(busy)
  );

  typedef struct {
    int              r;
    int              c;
    logic [9*PW-1:0] w;
  } exp_t;

  exp_t            expq[$];
  int              n_chk = 0;
  int              n_fail = 0;
  bit              chk_en = 1'b0;
  int              fd_cnt = 0;
  int              busy_fall = 0;
  int              win_cnt = 0;
  logic [9*PW-1:0] cap [H][W];
  int              t00[9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
  int              t23[9] = '{7, 8, 0, 11, 12, 0, 0, 0, 0};
  int              t22[9] = '{6, 7, 8, 10, 11, 12, 0, 0, 0};

  // Image content: ch0 = 4r+c+1, ch1 = ch0+100
  function automatic logic [PW-1:0] pix(int r, int c);
    logic [7:0] a;
    a = 8'(4 * r + c + 1);
    return {8'(a + 8'd100), a};
  endfunction

  // Window of centre (r,c): taps outside the image are zero
  function automatic logic [9*PW-1:0] model_win(int r, int c);
    logic [9*PW-1:0] w;
    w = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
          w[((dr + 1) * 3 + (dc + 1)) * PW +: PW] = pix(r + dr, c + dc);
    return w;
  endfunction

  task automatic check(string nm, logic [9*PW-1:0] act, logic [9*PW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic checki(string nm, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic check_taps(string nm, logic [9*PW-1:0] w, input int t[9]);
    for (int k = 0; k < 9; k++) begin
      checki($sformatf("%s_ch0_tap%0d", nm, k), int'(w[k*PW +: 8]), t[k]);
      checki($sformatf("%s_ch1_tap%0d", nm, k), int'(w[k*PW+8 +: 8]),
             (t[k] == 0) ? 0 : t[k] + 100);
    end
  endtask

  task automatic push_frame(bit s2);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (!s2 || (r % 2 == 0 && c % 2 == 0))
          expq.push_back('{r, c, model_win(r, c)});
  endtask

  task automatic clear_cap();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        cap[r][c] = '0;
  endtask

  // Output checker: every handshake against the model, stability while stalled
  task automatic compare_loop();
    exp_t            e;
    logic            prev_stall;
    logic            prev_busy;
    logic [9*PW-1:0] prev_win;
    logic [29:0]     prev_pos;
    prev_stall = 1'b0;
    prev_busy  = 1'b0;
    prev_win   = '0;
    prev_pos   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        prev_stall = 1'b0;
        prev_busy  = 1'b0;
      end else begin
        if (frame_done) fd_cnt++;
        if (prev_busy && !busy) busy_fall++;
        prev_busy = busy;
        if (chk_en && prev_stall) begin
          checki("hold_valid", int'(out_valid), 1);
          check("hold_window", out_window, prev_win);
          check("hold_pos", 144'({out_row, out_col}), 144'(prev_pos));
        end
        if (chk_en && out_valid && out_ready) begin
          if (expq.size() == 0) begin
            checki("extra_window_row", int'(out_row), -1);
          end else begin
            e = expq.pop_front();
            checki("win_row", int'(out_row), e.r);
            checki("win_col", int'(out_col), e.c);
            check($sformatf("win_data_%0d_%0d", e.r, e.c), out_window, e.w);
          end
          if (out_row < 15'(H) && out_col < 15'(W))
            cap[out_row][out_col] = out_window;
          win_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_win   = out_window;
        prev_pos   = {out_row, out_col};
      end
    end
  endtask

  // Present npix pixels in raster order; stride2 is inverted after pixel 0
  task automatic run_frame(bit s2, int npix, bit rnd_in, bit rnd_out, bit wait_done);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < npix && cyc < 4000) begin
      @(negedge clk);
      in_valid  = rnd_in ? 1'($urandom_range(0, 1)) : 1'b1;
      in_pixel  = pix(idx / W, idx % W);
      stride2   = (idx == 0) ? s2 : !s2;
      out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    checki("pixels_accepted", idx, npix);
    if (wait_done) begin
      cyc = 0;
      while (cyc < 4000) begin
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (frame_done) break;
        cyc++;
      end
      if (cyc >= 4000) checki("frame_done_timeout", cyc, 0);
    end
  endtask

  initial begin
    int wc0, fd0, bf0;
    reset     = 1'b0;
    stride2   = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b0;
    fork
      compare_loop();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checki("rst_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checki("rst_in_ready", int'(in_ready), 1);
    checki("rst_out_valid", int'(out_valid), 0);
    check("rst_out_window", out_window, '0);
    checki("rst_out_row", int'(out_row), 0);
    checki("rst_out_col", int'(out_col), 0);
    checki("rst_frame_done", int'(frame_done), 0);
    checki("rst_busy", int'(busy), 0);
    chk_en = 1'b1;

    // Stride 1, free-running
    clear_cap();
    push_frame(1'b0);
    wc0 = win_cnt;
    fd0 = fd_cnt;
    run_frame(1'b0, 12, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #3;
    checki("s1_windows", win_cnt - wc0, 12);
    checki("s1_frame_done", fd_cnt - fd0, 1);
    checki("s1_queue_left", expq.size(), 0);
    check_taps("s1_w00", cap[0][0], t00);
    check_taps("s1_w23", cap[2][3], t23);

    // Stride 2
    clear_cap();
    push_frame(1'b1);
    wc0 = win_cnt;
    run_frame(1'b1, 12, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #3;
    checki("s2_windows", win_cnt - wc0, 4);
    checki("s2_queue_left", expq.size(), 0);
    check_taps("s2_w22", cap[2][2], t22);

    // Random input valid and output backpressure
    push_frame(1'b0);
    wc0 = win_cnt;
    run_frame(1'b0, 12, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    #3;
    checki("rnd_windows", win_cnt - wc0, 12);
    checki("rnd_queue_left", expq.size(), 0);

    // Abort after 6 pixels, then a clean frame
    chk_en = 1'b0;
    run_frame(1'b0, 6, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checki("abort_busy_mid", int'(busy), 1);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checki("abort_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checki("abort_out_valid", int'(out_valid), 0);
    checki("abort_busy", int'(busy), 0);
    expq.delete();
    chk_en = 1'b1;
    clear_cap();
    push_frame(1'b0);
    wc0 = win_cnt;
    run_frame(1'b0, 12, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #3;
    checki("abort_windows", win_cnt - wc0, 12);
    checki("abort_queue_left", expq.size(), 0);
    check_taps("abort_w00", cap[0][0], t00);

    // Back-to-back frames: stride 1 then stride 2
    push_frame(1'b0);
    push_frame(1'b1);
    wc0 = win_cnt;
    fd0 = fd_cnt;
    bf0 = busy_fall;
    run_frame(1'b0, 12, 1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 12, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #3;
    checki("b2b_windows", win_cnt - wc0, 16);
    checki("b2b_frame_done", fd_cnt - fd0, 2);
    checki("b2b_busy_falls", busy_fall - bf0, 2);
    checki("b2b_queue_left", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
